// File: rtl/btb_update_unit.sv
`default_nettype none
// btb_update_unit: EX-stage write engine for the 2-way, 8-set BTB. It buffers
// resolved branches, reads both ways' tags, then issues at most one array write per record.
module btb_update_unit #(
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = ADDR_W - IDX_W - 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic [ADDR_W-1:0] req_target,
  input  logic              req_taken,
  output logic              tag_rd_en,
  output logic [IDX_W-1:0]  tag_rd_index,
  input  logic              tag_rd_valid1,
  input  logic              tag_rd_valid2,
  input  logic [TAG_W-1:0]  tag_rd_tag1,
  input  logic [TAG_W-1:0]  tag_rd_tag2,
  input  logic              lru_victim,
  output logic              wr_en,
  output logic              wr_way,
  output logic [IDX_W-1:0]  wr_index,
  output logic [TAG_W-1:0]  wr_tag,
  output logic [ADDR_W-1:0] wr_target,
  output logic              wr_valid,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_index,
  output logic              upd_hit1,
  output logic              upd_hit2,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP  = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_WRITE   = 2'd3;

  logic [IDX_W-1:0]  fifo_index  [FIFO_DEPTH];
  logic [TAG_W-1:0]  fifo_tag    [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_target [FIFO_DEPTH];
  logic              fifo_taken  [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic [IDX_W-1:0]  work_index;
  logic [TAG_W-1:0]  work_tag;
  logic [ADDR_W-1:0] work_target;
  logic              work_taken;

  logic              hit1;
  logic              hit2;
  logic              cmp_write;
  logic              cmp_way;
  logic              unused_pc_bits;

  // Word-aligned PCs: the byte offset never reaches the arrays.
  assign unused_pc_bits = ^req_pc[1:0];

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign req_ready = !full;
  assign push      = req_valid && !full && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_index[wr_ptr]  <= req_pc[IDX_W+1:2];
      fifo_tag[wr_ptr]    <= req_pc[ADDR_W-1:IDX_W+2];
      fifo_target[wr_ptr] <= req_target;
      fifo_taken[wr_ptr]  <= req_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_index  <= '0;
      work_tag    <= '0;
      work_target <= '0;
      work_taken  <= 1'b0;
    end else if (pop) begin
      work_index  <= fifo_index[rd_ptr];
      work_tag    <= fifo_tag[rd_ptr];
      work_target <= fifo_target[rd_ptr];
      work_taken  <= fifo_taken[rd_ptr];
    end
  end

  // A double hit resolves to way1 so the write stays one-hot.
  assign hit1      = tag_rd_valid1 && (tag_rd_tag1 == work_tag);
  assign hit2      = tag_rd_valid2 && (tag_rd_tag2 == work_tag) && !hit1;
  assign cmp_write = work_taken || hit1 || hit2;
  assign cmp_way   = hit1 ? 1'b0 : (hit2 ? 1'b1 : lru_victim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_LOOKUP;
          pop       = 1'b1;
        end
      end
      S_LOOKUP: state_nxt = S_COMPARE;
      S_COMPARE: begin
        if (cmp_write) begin
          state_nxt = S_WRITE;
        end else if (!empty) begin
          state_nxt = S_LOOKUP;
          pop       = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (!empty) begin
          state_nxt = S_LOOKUP;
          pop       = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
    end
  end

  always_comb begin
    tag_rd_en = (state == S_LOOKUP);
    busy      = !empty || (state != S_IDLE);
  end

  assign tag_rd_index = work_index;

  // Write and tracker fields are captured as COMPARE resolves and held for the WRITE cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_way    <= 1'b0;
      wr_index  <= '0;
      wr_tag    <= '0;
      wr_target <= '0;
      wr_valid  <= 1'b0;
      upd_valid <= 1'b0;
      upd_index <= '0;
      upd_hit1  <= 1'b0;
      upd_hit2  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      wr_way    <= 1'b0;
      wr_index  <= '0;
      wr_tag    <= '0;
      wr_target <= '0;
      wr_valid  <= 1'b0;
      upd_valid <= 1'b0;
      upd_index <= '0;
      upd_hit1  <= 1'b0;
      upd_hit2  <= 1'b0;
      if ((state == S_COMPARE) && cmp_write && !flush) begin
        wr_en     <= 1'b1;
        wr_way    <= cmp_way;
        wr_index  <= work_index;
        wr_tag    <= work_tag;
        wr_target <= work_target;
        wr_valid  <= work_taken;
        upd_valid <= work_taken;
        upd_index <= work_taken ? work_index : '0;
        upd_hit1  <= work_taken && !cmp_way;
        upd_hit2  <= work_taken && cmp_way;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_unit.sv
`default_nettype none
// tb_btb_update_unit: directed and randomized self-checking bench for the BTB
// update engine, with a behavioural BTB/tracker environment and a reference model.
module tb_btb_update_unit;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 3;
  localparam int TAG_W  = 27;
  localparam int EXP_W  = 1 + IDX_W + TAG_W + ADDR_W + 1 + 1 + IDX_W + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_target;
  logic              req_taken;
  logic              tag_rd_en;
  logic [IDX_W-1:0]  tag_rd_index;
  logic              tag_rd_valid1;
  logic              tag_rd_valid2;
  logic [TAG_W-1:0]  tag_rd_tag1;
  logic [TAG_W-1:0]  tag_rd_tag2;
  logic              lru_victim;
  logic              wr_en;
  logic              wr_way;
  logic [IDX_W-1:0]  wr_index;
  logic [TAG_W-1:0]  wr_tag;
  logic [ADDR_W-1:0] wr_target;
  logic              wr_valid;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_index;
  logic              upd_hit1;
  logic              upd_hit2;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tgt;
    logic              taken;
  } rec_t;

  btb_update_unit #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .req_target(req_target), .req_taken(req_taken),
    .tag_rd_en(tag_rd_en), .tag_rd_index(tag_rd_index),
    .tag_rd_valid1(tag_rd_valid1), .tag_rd_valid2(tag_rd_valid2),
    .tag_rd_tag1(tag_rd_tag1), .tag_rd_tag2(tag_rd_tag2), .lru_victim(lru_victim),
    .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index), .wr_tag(wr_tag),
    .wr_target(wr_target), .wr_valid(wr_valid),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_hit1(upd_hit1), .upd_hit2(upd_hit2),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: BTB arrays with one-cycle tag reads, plus the replacement tracker.
  logic              env_v   [2][8];
  logic [TAG_W-1:0]  env_tag [2][8];
  logic              env_lru [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 8; s++) begin
          env_v[w][s]   <= 1'b0;
          env_tag[w][s] <= '0;
        end
      for (int s = 0; s < 8; s++) env_lru[s] <= 1'b0;
      tag_rd_valid1 <= 1'b0;
      tag_rd_valid2 <= 1'b0;
      tag_rd_tag1   <= '0;
      tag_rd_tag2   <= '0;
    end else begin
      if (tag_rd_en) begin
        tag_rd_valid1 <= env_v[0][tag_rd_index];
        tag_rd_valid2 <= env_v[1][tag_rd_index];
        tag_rd_tag1   <= env_tag[0][tag_rd_index];
        tag_rd_tag2   <= env_tag[1][tag_rd_index];
      end
      if (wr_en) begin
        env_v[wr_way][wr_index]   <= wr_valid;
        env_tag[wr_way][wr_index] <= wr_tag;
      end
      if (upd_valid) env_lru[upd_index] <= upd_hit1;
    end
  end

  assign lru_victim = env_lru[tag_rd_index];

  // Reference model state: what the BTB should hold after each record, in acceptance order.
  logic             gv   [2][8];
  logic [TAG_W-1:0] gtag [2][8];
  logic             glru [8];

  task automatic model_apply(input rec_t r, output logic do_wr, output logic [EXP_W-1:0] ev);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    logic             way;
    int               hw;
    idx = IDX_W'((r.pc >> 2) % 8);
    tg  = TAG_W'(r.pc >> 5);
    hw  = -1;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && gv[w][idx] && gtag[w][idx] == tg) hw = w;
    if (r.taken) begin
      way = (hw >= 0) ? 1'(hw) : glru[idx];
      gv[way][idx]   = 1'b1;
      gtag[way][idx] = tg;
      glru[idx]      = (way == 1'b0);
      do_wr = 1'b1;
      ev = {way, idx, tg, r.tgt, 1'b1, 1'b1, idx, way == 1'b0, way == 1'b1};
    end else if (hw >= 0) begin
      way = 1'(hw);
      gv[way][idx] = 1'b0;
      do_wr = 1'b1;
      ev = {way, idx, tg, r.tgt, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    end else begin
      do_wr = 1'b0;
      ev = '0;
    end
  endtask

  function automatic rec_t rand_rec(input logic force_taken);
    rec_t r;
    r.pc    = (32'($urandom_range(0, 3) + 32'h100) << 5) | (32'($urandom_range(0, 7)) << 2)
              | 32'($urandom_range(0, 3));
    r.tgt   = $urandom;
    r.taken = force_taken ? 1'b1 : 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        gv[w][s]   = 1'b0;
        gtag[w][s] = '0;
      end
    for (int s = 0; s < 8; s++) glru[s] = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_one(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                          output int acc);
    req_valid  = 1'b1;
    req_pc     = pc;
    req_target = tgt;
    req_taken  = tk;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      if (req_ready) acc = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_wr(input int acc, output int d);
    while (!wr_en && (cyc - acc) < 12) @(negedge clk);
    d = wr_en ? (cyc - acc) : -1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_pc = '0;
    req_target = '0;
    req_taken = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, tag_rd_en, tag_rd_index, wr_en, wr_valid, wr_way, wr_index, wr_tag,
         wr_target, upd_valid, upd_index, upd_hit1, upd_hit2} !== {1'b1, 76'd0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b wr_en=%b upd_valid=%b rd_en=%b, required ready=1 rest 0",
               req_ready, busy, wr_en, upd_valid, tag_rd_en);
    end
    do_reset();
    checks++;
    if ({req_ready, busy, wr_en, upd_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: ready/busy/wr_en/upd=%b, required 1000",
               {req_ready, busy, wr_en, upd_valid});
    end
  endtask

  task automatic test_taken_alloc();
    int a, d;
    send_one(32'h0000_1010, 32'h0000_2000, 1'b1, a);
    @(negedge clk);
    checks++;
    if ({tag_rd_en, tag_rd_index} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL alloc_lookup: rd_en=%b idx=%0d, required 1 4", tag_rd_en, tag_rd_index);
    end
    wait_wr(a, d);
    checks++;
    if (d !== 4) begin
      errors++;
      $display("FAIL alloc_latency: wr_en after %0d cycles, required 4", d);
    end
    checks++;
    if ({wr_way, wr_index, wr_tag, wr_valid, wr_target} !== {1'b0, 3'd4, 27'h80, 1'b1, 32'h2000}) begin
      errors++;
      $display("FAIL alloc_write: way=%b idx=%0d tag=%h v=%b tgt=%h, required 0 4 80 1 2000",
               wr_way, wr_index, wr_tag, wr_valid, wr_target);
    end
    checks++;
    if ({upd_valid, upd_index, upd_hit1, upd_hit2} !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL alloc_upd: v=%b idx=%0d h1=%b h2=%b, required 1 4 1 0",
               upd_valid, upd_index, upd_hit1, upd_hit2);
    end
    wait_idle();
  endtask

  task automatic test_taken_hit();
    int a, d;
    send_one(32'h0000_1010, 32'h0000_3000, 1'b1, a);
    wait_wr(a, d);
    checks++;
    if ({wr_way, wr_index, wr_tag, wr_valid, wr_target, upd_valid, upd_hit1, upd_hit2} !==
        {1'b0, 3'd4, 27'h80, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b0} || d !== 4) begin
      errors++;
      $display("FAIL hit_update: d=%0d way=%b tgt=%h upd=%b h1=%b h2=%b, required 4 0 3000 1 1 0",
               d, wr_way, wr_target, upd_valid, upd_hit1, upd_hit2);
    end
    wait_idle();
  endtask

  task automatic test_taken_miss();
    int a, d;
    send_one(32'h0000_1030, 32'h0000_4000, 1'b1, a);
    wait_wr(a, d);
    checks++;
    if ({wr_way, wr_index, wr_tag, wr_valid, wr_target, upd_valid, upd_index, upd_hit1, upd_hit2} !==
        {1'b1, 3'd4, 27'h81, 1'b1, 32'h4000, 1'b1, 3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL miss_alloc: way=%b tag=%h tgt=%h h1=%b h2=%b, required 1 81 4000 0 1",
               wr_way, wr_tag, wr_target, upd_hit1, upd_hit2);
    end
    wait_idle();
  endtask

  task automatic test_not_taken();
    int a, d;
    logic saw_wr, busy3, busy4;
    send_one(32'h0000_1030, 32'h0000_5000, 1'b0, a);
    wait_wr(a, d);
    checks++;
    if ({wr_way, wr_index, wr_tag, wr_valid, upd_valid, upd_index, upd_hit1, upd_hit2} !==
        {1'b1, 3'd4, 27'h81, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0} || d !== 4) begin
      errors++;
      $display("FAIL nt_invalidate: d=%0d way=%b v=%b upd=%b, required 4 1 0 0",
               d, wr_way, wr_valid, upd_valid);
    end
    wait_idle();
    send_one(32'h0000_1030, 32'h0000_6000, 1'b0, a);
    saw_wr = 1'b0;
    busy3 = 1'b0;
    busy4 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (wr_en || upd_valid) saw_wr = 1'b1;
      if (k == 3) busy3 = busy;
      if (k == 4) busy4 = busy;
      @(negedge clk);
    end
    checks++;
    if (saw_wr !== 1'b0) begin
      errors++;
      $display("FAIL nt_miss_write: saw write strobe=%b, required 0", saw_wr);
    end
    checks++;
    if ({busy3, busy4} !== 2'b10) begin
      errors++;
      $display("FAIL nt_miss_idle: busy at compare/after=%b, required 10", {busy3, busy4});
    end
  endtask

  task automatic test_back_to_back();
    rec_t recs [4];
    rec_t pend [$];
    int wr_cyc [$];
    int acc, acc_at_low;
    logic dw;
    logic [EXP_W-1:0] ev, ov;
    do_reset();
    for (int i = 0; i < 4; i++) recs[i] = rand_rec(1'b1);
    acc = 0;
    acc_at_low = -1;
    for (int c = 0; c < 40; c++) begin
      if (wr_en) begin
        ov = {wr_way, wr_index, wr_tag, wr_target, wr_valid, upd_valid, upd_index, upd_hit1, upd_hit2};
        dw = 1'b0;
        ev = '0;
        while (!dw && pend.size() > 0) model_apply(pend.pop_front(), dw, ev);
        wr_cyc.push_back(c);
        checks++;
        if (!dw || ov !== ev) begin
          errors++;
          $display("FAIL b2b_write n=%0d: got %h required %h", wr_cyc.size(), ov, ev);
        end
      end
      if (acc < 4) begin
        req_valid  = 1'b1;
        req_pc     = recs[acc].pc;
        req_target = recs[acc].tgt;
        req_taken  = recs[acc].taken;
        if (req_ready) begin
          pend.push_back(recs[acc]);
          acc++;
        end else if (acc_at_low < 0) begin
          acc_at_low = acc;
        end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (acc_at_low !== 3) begin
      errors++;
      $display("FAIL b2b_ready_drop: accepted %0d before ready fell, required 3", acc_at_low);
    end
    checks++;
    if (wr_cyc.size() !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d writes, required 4", wr_cyc.size());
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      checks++;
      if (wr_cyc[i] - wr_cyc[i-1] !== 3) begin
        errors++;
        $display("FAIL b2b_spacing %0d: gap %0d, required 3", i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    rec_t pend [$];
    rec_t cur;
    logic have, dw;
    logic [EXP_W-1:0] ev, ov;
    int sent, budget;
    do_reset();
    have = 1'b0;
    sent = 0;
    budget = 0;
    while ((sent < 40 || have || busy) && budget < 3000) begin
      ov = {wr_way, wr_index, wr_tag, wr_target, wr_valid, upd_valid, upd_index, upd_hit1, upd_hit2};
      if (wr_en) begin
        dw = 1'b0;
        ev = '0;
        while (!dw && pend.size() > 0) model_apply(pend.pop_front(), dw, ev);
        checks++;
        if (!dw || ov !== ev) begin
          errors++;
          $display("FAIL rnd_write cyc=%0d: got %h required %h (expected write=%b)", cyc, ov, ev, dw);
        end
      end else begin
        checks++;
        if (ov !== '0) begin
          errors++;
          $display("FAIL rnd_idle_zero cyc=%0d: got %h required 0", cyc, ov);
        end
      end
      if (!have && sent < 40 && $urandom_range(0, 2) == 0) begin
        cur = rand_rec(1'b0);
        have = 1'b1;
      end
      req_valid  = have;
      req_pc     = cur.pc;
      req_target = cur.tgt;
      req_taken  = cur.taken;
      if (have && req_ready) begin
        pend.push_back(cur);
        have = 1'b0;
        sent++;
      end
      @(negedge clk);
      budget++;
    end
    req_valid = 1'b0;
    checks++;
    if (budget >= 3000) begin
      errors++;
      $display("FAIL rnd_timeout: sent=%0d busy=%b, required drain within 3000 cycles", sent, busy);
    end
    while (pend.size() > 0) begin
      model_apply(pend.pop_front(), dw, ev);
      checks++;
      if (dw) begin
        errors++;
        $display("FAIL rnd_missing_write: got none required %h", ev);
      end
    end
  endtask

  task automatic test_flush();
    int a, b;
    logic saw_wr, saw_busy;
    do_reset();
    send_one(32'h0000_1050, 32'h0000_7000, 1'b1, a);
    send_one(32'h0000_1070, 32'h0000_8000, 1'b1, b);
    while (cyc < a + 3) @(negedge clk);
    flush      = 1'b1;
    req_valid  = 1'b1;
    req_pc     = 32'h0000_1090;
    req_target = 32'h0000_9000;
    req_taken  = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if ({wr_en, upd_valid, busy, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL flush_next: wr_en/upd/busy/ready=%b, required 0001",
               {wr_en, upd_valid, busy, req_ready});
    end
    saw_wr = 1'b0;
    saw_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (wr_en) saw_wr = 1'b1;
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({saw_wr, saw_busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_discard: write/busy seen=%b, required 00", {saw_wr, saw_busy});
    end
  endtask

  task automatic test_reset_mid();
    int a, b, d;
    logic saw_wr;
    do_reset();
    send_one(32'h0000_1070, 32'h0000_6000, 1'b1, a);
    send_one(32'h0000_1074, 32'h0000_6100, 1'b1, b);
    wait_wr(a, d);
    checks++;
    if (d !== 4) begin
      errors++;
      $display("FAIL rstmid_reach_write: wr_en after %0d cycles, required 4", d);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, upd_valid, tag_rd_en, busy, req_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_async: wr_en/upd/rd/busy/ready=%b, required 00001",
               {wr_en, upd_valid, tag_rd_en, busy, req_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (wr_en || busy) saw_wr = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_wr !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: activity after reset=%b, required 0", saw_wr);
    end
  endtask

  initial begin
    test_reset();
    test_taken_alloc();
    test_taken_hit();
    test_taken_miss();
    test_not_taken();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_update_unit.md
Name: btb_update_unit

Overview:
- EX-stage write-side engine for the 2-way, 8-set branch target buffer (BTB).
- Accepts resolved-branch records from EX and buffers them in a small FIFO.
- For each record it reads both ways' tags at the set, then decides hit, allocate or invalidate, and issues a single array write.
- Drives the replacement-tracker update strobe (hit way or newly filled way), taking the victim choice from the tracker's per-set bit.

Parameters:
ADDR_W, 32, PC/target width
IDX_W, 3, set index width (8 sets); index = pc[IDX_W+1:2]
TAG_W, 27, tag width = ADDR_W-IDX_W-2; tag = pc[ADDR_W-1:IDX_W+2]
FIFO_DEPTH, 2, request buffer entries (power of two)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous discard of buffered and in-flight work
req_valid  in  1  EX resolved-branch record valid
req_ready  out  1  unit can accept record
req_pc  in  ADDR_W  branch PC
req_target  in  ADDR_W  resolved target
req_taken  in  1  branch resolved taken
tag_rd_en  out  1  tag read strobe to BTB arrays
tag_rd_index  out  IDX_W  set to read
tag_rd_valid1, tag_rd_valid2  in  1 each  way valid bits, returned one cycle after tag_rd_en
tag_rd_tag1, tag_rd_tag2  in  TAG_W each  way tags, returned one cycle after tag_rd_en
lru_victim  in  1  tracker bit for tag_rd_index set: 0 = way1 is victim, 1 = way2 is victim
wr_en  out  1  array write strobe
wr_way  out  1  0 = way1, 1 = way2
wr_index  out  IDX_W  set written
wr_tag  out  TAG_W  tag written
wr_target  out  ADDR_W  target written
wr_valid  out  1  valid bit written
upd_valid  out  1  tracker update strobe
upd_index  out  IDX_W  set to update in tracker
upd_hit1, upd_hit2  out  1 each  way touched (one-hot when upd_valid)
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, FSM = IDLE.
  - All outputs 0, except req_ready = 1.
- FIFO and handshake:
  - Push when req_valid && req_ready; req_ready = !full.
  - Pop occurs only on entry to LOOKUP.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOOKUP, COMPARE, WRITE.
  - IDLE: if FIFO non-empty, pop the head into the working register and go to LOOKUP.
  - LOOKUP: tag_rd_en = 1, tag_rd_index = working index; go to COMPARE.
  - COMPARE:
    - Sample tag_rd_* and lru_victim.
    - hit1 = valid1 && tag1 == tag; hit2 likewise; if both hit, treat as hit1 only.
    - Taken + hit: go to WRITE, way = hit way.
    - Taken + miss: go to WRITE, way = lru_victim.
    - Not-taken + hit: go to WRITE, way = hit way, wr_valid = 0 (invalidate).
    - Not-taken + miss: no write. Go to LOOKUP with pop if FIFO non-empty, else IDLE.
  - WRITE:
    - Assert wr_en for exactly one cycle with the registered fields.
    - Taken case: wr_valid = 1; also assert upd_valid with upd_index = set and upd_hit1/upd_hit2 one-hot for the written way.
    - Invalidate case: upd_valid = 0.
    - Next state: LOOKUP with pop if FIFO non-empty, else IDLE.
- Latency and throughput:
  - Accept cycle N (FSM IDLE, FIFO empty): IDLE pops at N+1, LOOKUP at N+2, COMPARE at N+3, wr_en at N+4.
  - Back-to-back throughput is one record per 3 cycles.
- Same-set ordering:
  - The array write at the end of WRITE is visible to the following LOOKUP read, so consecutive records to one set see each other.
  - No forwarding inside the unit.
- All wr_*/upd_* outputs are registered, and zero when their strobe is low.
- flush:
  - Next edge: FIFO empty, FSM = IDLE, no wr_en/upd_valid that cycle.
  - A req handshaken in the flush cycle is discarded.
  - flush has priority over every transition.
- Reset mid-operation aborts the in-flight record with no partial write.

Test Plan:
- Reset, then taken pc=0x0000_1010, target=0x2000, set 4 empty, lru_victim=0 -> wr_en 4 cycles after accept; wr_way=0, wr_index=4, wr_tag=0x80, wr_valid=1; upd_valid with upd_hit1=1.
- Same pc re-sent taken with target=0x3000, tag_rd returns way1 valid and matching -> wr_way=0, wr_target=0x3000, upd_hit1=1, lru_victim ignored.
- Set 4 has way1 holding another tag, way2 invalid, lru_victim=1, taken miss -> wr_way=1, upd_hit2=1.
- Not-taken hit on way2 -> wr_en with wr_valid=0, upd_valid=0; not-taken miss -> no wr_en, FSM back to IDLE after COMPARE.
- Hold req_valid for 4 records while tag reads stall behind FSM -> req_ready drops after 2 buffered; all 4 written in order, wr_en spaced exactly 3 cycles.
- Assert flush during COMPARE with 1 record queued -> no wr_en, busy=0 next cycle; rst_n pulsed low in WRITE -> wr_en clears immediately, req_ready=1.
